// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: states, opcodes, jump
// conditions, ALU codes and small opcode-class helpers.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_INCREMENT = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_JUMP   = 4'b1000;
  localparam logic [3:0] OP_JCOND  = 4'b1001;
  localparam logic [3:0] OP_INPUT  = 4'b1010;
  localparam logic [3:0] OP_OUTPUT = 4'b1110;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_OUT  = 5'b00010;
  localparam logic [4:0] ALU_PASS = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b01100;
  localparam logic [4:0] ALU_INC  = 5'b10100;
  localparam logic [4:0] ALU_NONE = 5'b00000;

  // Opcodes that perform a memory transfer in EXECUTE
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_AND) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_INPUT) || (op == OP_OUTPUT);
  endfunction

  // Opcodes that write the accumulator
  function automatic logic is_acc_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_AND) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_INPUT);
  endfunction

  // Opcodes whose ALU result updates carry/zero
  function automatic logic is_flag_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ctrl_flags.sv
// Carry/zero flag registers with load enable and synchronous clear.
module ctrl_flags (
  input  logic clk,
  input  logic clr_i,
  input  logic ld_i,
  input  logic carry_i,
  input  logic zero_i,
  output logic carry_o,
  output logic zero_o
);

  logic carry_q;
  logic zero_q;

  // Capture ALU flags only when the sequencer says the result is valid
  always_ff @(posedge clk) begin
    if (clr_i) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ld_i) begin
      carry_q <= carry_i;
      zero_q  <= zero_i;
    end
  end

  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Accumulator-processor control sequencer: fetch/decode/execute/increment
// with memory handshake, HALT/run-resume and a retired-instruction counter.
//
// state      | meaning
// IDLE      0 | after clear, goes straight to FETCH
// FETCH     1 | memory read of next instruction, IR loads on ack
// DECODE    2 | opcode strobes presented, no side effects
// EXECUTE   3 | memory op waits for ack; jumps load PC here
// INCREMENT 4 | PC steps, instruction retires
// HALTED    5 | all strobes off until run
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int IR_W    = 8,
  parameter int USE_ACK = 1,
  parameter int RET_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IR_W-1:0]  ir,
  input  logic             carry,
  input  logic             zero,
  input  logic             mem_ack,
  input  logic             run,
  output logic             rw,
  output logic [4:0]       alu,
  output logic             muxa,
  output logic             muxb,
  output logic             muxc,
  output logic             en_ir,
  output logic             en_da,
  output logic             en_pc,
  output logic             mem_req,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [RET_W-1:0] ret_cnt
);

  state_e           state_q, state_d;
  logic [RET_W-1:0] ret_q;
  logic [3:0]       op;
  logic [1:0]       cond;
  logic             ack;
  logic             carry_reg, zero_reg;
  logic             cond_true, jump_taken, flag_ld, retire;
  logic [4:0]       alu_dec;
  logic             unused_ir;

  assign op        = ir[IR_W-1 -: 4];
  assign cond      = ir[IR_W-5 -: 2];
  assign unused_ir = ^ir[IR_W-7:0];
  assign ack       = (USE_ACK != 0) ? mem_ack : 1'b1;

  // Jump condition evaluated against the registered flags
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_Z:  cond_true = zero_reg;
      COND_NZ: cond_true = ~zero_reg;
      COND_C:  cond_true = carry_reg;
      default: cond_true = ~carry_reg;
    endcase
  end

  assign jump_taken = (op == OP_JUMP) || ((op == OP_JCOND) && cond_true);

  // Opcode to ALU operation for DECODE/EXECUTE
  always_comb begin
    alu_dec = ALU_NONE;
    case (op)
      OP_ADD:                               alu_dec = ALU_ADD;
      OP_AND:                               alu_dec = ALU_AND;
      OP_OUTPUT:                            alu_dec = ALU_OUT;
      OP_LOAD, OP_INPUT, OP_JUMP, OP_JCOND: alu_dec = ALU_PASS;
      OP_SUB:                               alu_dec = ALU_SUB;
      default:                              alu_dec = ALU_NONE;
    endcase
  end

  assign flag_ld = (state_q == ST_EXECUTE) && is_flag_op(op) && ack;
  assign retire  = (state_q == ST_INCREMENT) ||
                   ((state_q == ST_EXECUTE) && jump_taken);

  ctrl_flags u_flags (
    .clk     (clk),
    .clr_i   (clr),
    .ld_i    (flag_ld),
    .carry_i (carry),
    .zero_i  (zero),
    .carry_o (carry_reg),
    .zero_o  (zero_reg)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     state_d = ack ? ST_DECODE : ST_FETCH;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (op == OP_HALT)   state_d = ST_HALTED;
        else if (is_mem_op(op)) state_d = ack ? ST_INCREMENT : ST_EXECUTE;
        else if (jump_taken) state_d = ST_FETCH;
        else                 state_d = ST_INCREMENT;
      end
      ST_INCREMENT: state_d = ST_FETCH;
      ST_HALTED:    state_d = run ? ST_INCREMENT : ST_HALTED;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from state, opcode and handshake
  always_comb begin
    rw      = 1'b0;
    alu     = ALU_NONE;
    muxa    = 1'b0;
    muxb    = 1'b0;
    muxc    = 1'b0;
    en_ir   = 1'b0;
    en_da   = 1'b0;
    en_pc   = 1'b0;
    mem_req = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        en_ir   = ack;
      end
      ST_DECODE, ST_EXECUTE: begin
        alu  = alu_dec;
        muxb = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_AND) || (op == OP_SUB);
        muxc = (op == OP_INPUT) || (op == OP_OUTPUT);
        if (state_q == ST_EXECUTE) begin
          mem_req = is_mem_op(op);
          rw      = (op == OP_OUTPUT);
          en_da   = is_acc_op(op) && ack;
          en_pc   = jump_taken;
        end
      end
      ST_INCREMENT: begin
        alu   = ALU_INC;
        muxa  = 1'b1;
        en_pc = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (clr)         ret_q <= '0;
    else if (retire) ret_q <= ret_q + RET_W'(1);
  end

  assign state_o = state_q;
  assign ret_cnt = ret_q;

endmodule
